instr_decode_stage: RTL and testbench

- Single-entry decode stage between the fetch queue and the issue stage.
- Accepts one 32-bit RV64 instruction per cycle and decodes opcode class, register indices, immediate, control-flow flag and exceptions.
- Holds the result in an output register until the issue stage acknowledges it.

---
 rtl/instr_decode_stage.sv | 205 ++++++++++++++++++++
 tb/tb_instr_decode_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_stage.sv
// Single-entry RV64 decode stage: decodes one fetched instruction into a held issue entry.
// Optional feature macro: DECODE_DEBUG_REQ_EN (debug request turns the accepted entry into a debug trap).
module instr_decode_stage #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            debug_req_i,
  input  logic [31:0]     fetch_instr_i,
  input  logic [XLEN-1:0] fetch_pc_i,
  input  logic            fetch_valid_i,
  output logic            fetch_ready_o,
  output logic            issue_valid_o,
  output logic [31:0]     issue_instr_o,
  output logic [XLEN-1:0] issue_pc_o,
  output logic [2:0]      issue_fu_o,
  output logic [4:0]      issue_rd_o,
  output logic [4:0]      issue_rs1_o,
  output logic [4:0]      issue_rs2_o,
  output logic [XLEN-1:0] issue_imm_o,
  output logic            issue_ex_valid_o,
  output logic [XLEN-1:0] issue_ex_cause_o,
  output logic            is_ctrl_flow_o,
  input  logic            issue_ack_i,
  input  logic [1:0]      priv_lvl_i,
  input  logic [1:0]      fs_i,
  input  logic [1:0]      irq_i,
  input  logic            irq_en_i,
  input  logic            debug_mode_i,
  input  logic            tvm_i,
  input  logic            tw_i,
  input  logic            tsr_i
);

  localparam int unsigned CW = XLEN - 1;

  typedef enum logic [2:0] {
    FU_NONE = 3'd0, FU_ALU = 3'd1, FU_LSU = 3'd2, FU_BRANCH = 3'd3,
    FU_CSR = 3'd4, FU_MULT = 3'd5, FU_FPU = 3'd6
  } fu_e;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_32    = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  localparam logic [6:0] OPC_OP_FP    = 7'b1010011;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [6:0]      funct7;
  logic            accept;

  fu_e             fu_d, fu_q;
  logic [XLEN-1:0] imm_d, imm_q;
  logic            ctrl_d, ctrl_q;
  logic            illegal_op;
  logic            ex_valid_d, ex_valid_q;
  logic [XLEN-1:0] ex_cause_d, ex_cause_q;
  logic            valid_q;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_q;

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic            is_priv, is_ecall, is_ebreak, is_sret, is_mret, is_wfi, is_sfence;
  logic            illegal, irq_pending;

  assign instr  = fetch_instr_i;
  assign opcode = instr[6:0];
  assign funct7 = instr[31:25];

  assign fetch_ready_o = !flush_i && (!valid_q || issue_ack_i);
  assign accept        = fetch_valid_i && fetch_ready_o;

  assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
  assign imm_j = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Privileged SYSTEM encodings (funct3 = 000)
  assign is_priv   = (opcode == OPC_SYSTEM) && (instr[14:12] == 3'b000);
  assign is_ecall  = is_priv && (instr[31:7] == 25'd0);
  assign is_ebreak = is_priv && (instr[31:20] == 12'h001) && (instr[19:7] == 13'd0);
  assign is_sret   = is_priv && (instr[31:20] == 12'h102) && (instr[19:7] == 13'd0);
  assign is_mret   = is_priv && (instr[31:20] == 12'h302) && (instr[19:7] == 13'd0);
  assign is_wfi    = is_priv && (instr[31:20] == 12'h105) && (instr[19:7] == 13'd0);
  assign is_sfence = is_priv && (funct7 == 7'b0001001) && (instr[11:7] == 5'd0);

  // Opcode class, immediate format and control-flow flag
  always_comb begin
    fu_d       = FU_NONE;
    imm_d      = '0;
    ctrl_d     = 1'b0;
    illegal_op = 1'b0;
    case (opcode)
      OPC_OP:                     fu_d = (funct7 == 7'b0000001) ? FU_MULT : FU_ALU;
      OPC_OP_32:                  fu_d = FU_ALU;
      OPC_OP_IMM, OPC_OP_IMM32:   begin fu_d = FU_ALU; imm_d = imm_i; end
      OPC_LUI, OPC_AUIPC:         begin fu_d = FU_ALU; imm_d = imm_u; end
      OPC_LOAD:                   begin fu_d = FU_LSU; imm_d = imm_i; end
      OPC_STORE:                  begin fu_d = FU_LSU; imm_d = imm_s; end
      OPC_JAL:                    begin fu_d = FU_BRANCH; imm_d = imm_j; ctrl_d = 1'b1; end
      OPC_JALR:                   begin fu_d = FU_BRANCH; imm_d = imm_i; ctrl_d = 1'b1; end
      OPC_BRANCH:                 begin fu_d = FU_BRANCH; imm_d = imm_b; ctrl_d = 1'b1; end
      OPC_SYSTEM:                 begin fu_d = FU_CSR; imm_d = imm_i; end
      OPC_LOAD_FP:                begin fu_d = FU_FPU; imm_d = imm_i; end
      OPC_STORE_FP:               begin fu_d = FU_FPU; imm_d = imm_s; end
      OPC_OP_FP:                  fu_d = FU_FPU;
      default:                    illegal_op = 1'b1;
    endcase
  end

  assign illegal = illegal_op
                || ((fu_d == FU_FPU) && (fs_i == 2'd0))
                || (is_sfence && tvm_i && (priv_lvl_i == PRIV_S))
                || (is_wfi && tw_i && (priv_lvl_i != PRIV_M))
                || (is_sret && ((tsr_i && (priv_lvl_i == PRIV_S)) || (priv_lvl_i == PRIV_U)))
                || (is_mret && (priv_lvl_i != PRIV_M));

  assign irq_pending = irq_en_i && (irq_i != 2'b00) && !debug_mode_i;

`ifndef DECODE_DEBUG_REQ_EN
  logic unused_debug_req;
  assign unused_debug_req = debug_req_i;
`endif

  // Exception selection, highest priority first
  always_comb begin
    ex_valid_d = 1'b1;
    ex_cause_d = '0;
`ifdef DECODE_DEBUG_REQ_EN
    if (debug_req_i && !debug_mode_i) ex_cause_d = XLEN'(24);
    else
`endif
    if (irq_pending)  ex_cause_d = {1'b1, irq_i[0] ? CW'(7) : CW'(11)};
    else if (illegal) ex_cause_d = XLEN'(2);
    else if (is_ebreak) ex_cause_d = XLEN'(3);
    else if (is_ecall) begin
      case (priv_lvl_i)
        PRIV_U:  ex_cause_d = XLEN'(8);
        PRIV_S:  ex_cause_d = XLEN'(9);
        default: ex_cause_d = XLEN'(11);
      endcase
    end else begin
      ex_valid_d = 1'b0;
    end
  end

  // Output entry register; flush beats accept, accept beats ack-clear
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      instr_q    <= '0;
      pc_q       <= '0;
      fu_q       <= FU_NONE;
      imm_q      <= '0;
      ctrl_q     <= 1'b0;
      ex_valid_q <= 1'b0;
      ex_cause_q <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= 1'b0;
    end else if (accept) begin
      valid_q    <= 1'b1;
      instr_q    <= fetch_instr_i;
      pc_q       <= fetch_pc_i;
      fu_q       <= fu_d;
      imm_q      <= imm_d;
      ctrl_q     <= ctrl_d;
      ex_valid_q <= ex_valid_d;
      ex_cause_q <= ex_cause_d;
    end else if (issue_ack_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= 1'b0;
    end
  end

  assign issue_valid_o    = valid_q;
  assign issue_instr_o    = instr_q;
  assign issue_pc_o       = pc_q;
  assign issue_fu_o       = fu_q;
  assign issue_rd_o       = instr_q[11:7];
  assign issue_rs1_o      = instr_q[19:15];
  assign issue_rs2_o      = instr_q[24:20];
  assign issue_imm_o      = imm_q;
  assign issue_ex_valid_o = ex_valid_q;
  assign issue_ex_cause_o = ex_cause_q;
  assign is_ctrl_flow_o   = ctrl_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed self-checking bench for instr_decode_stage.
module tb_instr_decode_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i, debug_req_i;
  logic [31:0] fetch_instr_i;
  logic [63:0] fetch_pc_i;
  logic        fetch_valid_i, fetch_ready_o;
  logic        issue_valid_o;
  logic [31:0] issue_instr_o;
  logic [63:0] issue_pc_o;
  logic [2:0]  issue_fu_o;
  logic [4:0]  issue_rd_o, issue_rs1_o, issue_rs2_o;
  logic [63:0] issue_imm_o;
  logic        issue_ex_valid_o;
  logic [63:0] issue_ex_cause_o;
  logic        is_ctrl_flow_o;
  logic        issue_ack_i;
  logic [1:0]  priv_lvl_i, fs_i, irq_i;
  logic        irq_en_i, debug_mode_i, tvm_i, tw_i, tsr_i;

  int n_checks = 0;
  int n_fail   = 0;

  instr_decode_stage #(.XLEN(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .debug_req_i(debug_req_i),
    .fetch_instr_i(fetch_instr_i), .fetch_pc_i(fetch_pc_i), .fetch_valid_i(fetch_valid_i),
    .fetch_ready_o(fetch_ready_o), .issue_valid_o(issue_valid_o), .issue_instr_o(issue_instr_o),
    .issue_pc_o(issue_pc_o), .issue_fu_o(issue_fu_o), .issue_rd_o(issue_rd_o),
    .issue_rs1_o(issue_rs1_o), .issue_rs2_o(issue_rs2_o), .issue_imm_o(issue_imm_o),
    .issue_ex_valid_o(issue_ex_valid_o), .issue_ex_cause_o(issue_ex_cause_o),
    .is_ctrl_flow_o(is_ctrl_flow_o), .issue_ack_i(issue_ack_i), .priv_lvl_i(priv_lvl_i),
    .fs_i(fs_i), .irq_i(irq_i), .irq_en_i(irq_en_i), .debug_mode_i(debug_mode_i),
    .tvm_i(tvm_i), .tw_i(tw_i), .tsr_i(tsr_i)
  );

  always #5 clk_i = ~clk_i;

  // Advance one rising edge; outputs are then sampled at the falling edge
  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_i = 1'b1; flush_i = 1'b0; debug_req_i = 1'b0;
    fetch_instr_i = '0; fetch_pc_i = '0; fetch_valid_i = 1'b0; issue_ack_i = 1'b0;
    priv_lvl_i = 2'd3; fs_i = 2'd1; irq_i = 2'b00; irq_en_i = 1'b0;
    debug_mode_i = 1'b0; tvm_i = 1'b0; tw_i = 1'b0; tsr_i = 1'b0;
    repeat (3) step();
    rst_i = 1'b0;
    step();
    n_checks++;
    if (issue_valid_o !== 1'b0 || fetch_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_handshake: valid=%b ready=%b, want valid=0 ready=1", issue_valid_o, fetch_ready_o);
    end
    n_checks++;
    if (issue_fu_o !== 3'd0 || issue_ex_valid_o !== 1'b0 || is_ctrl_flow_o !== 1'b0 || issue_imm_o !== 64'd0) begin
      n_fail++; $display("FAIL reset_fields: fu=%0d ex=%b ctrl=%b imm=%h, want all 0", issue_fu_o, issue_ex_valid_o, is_ctrl_flow_o, issue_imm_o);
    end
  endtask

  task automatic test_alu();
    fetch_instr_i = 32'h000000B3; fetch_pc_i = 64'h80000000; fetch_valid_i = 1'b1;
    step();
    fetch_valid_i = 1'b0;
    n_checks++;
    if (issue_valid_o !== 1'b1 || issue_fu_o !== 3'd1 || issue_rd_o !== 5'd1 || is_ctrl_flow_o !== 1'b0 || issue_ex_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL alu_add: valid=%b fu=%0d rd=%0d ctrl=%b ex=%b, want 1 1 1 0 0",
                         issue_valid_o, issue_fu_o, issue_rd_o, is_ctrl_flow_o, issue_ex_valid_o);
    end
    n_checks++;
    if (issue_pc_o !== 64'h80000000 || issue_instr_o !== 32'h000000B3 || issue_ex_cause_o !== 64'd0) begin
      n_fail++; $display("FAIL alu_mirror: pc=%h instr=%h cause=%h", issue_pc_o, issue_instr_o, issue_ex_cause_o);
    end
    issue_ack_i = 1'b1;
    step();
    issue_ack_i = 1'b0;
    n_checks++;
    if (issue_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL ack_clear: valid=%b, want 0", issue_valid_o);
    end
  endtask

  task automatic test_jal();
    fetch_instr_i = 32'h0000006F; fetch_pc_i = 64'h80000004; fetch_valid_i = 1'b1;
    issue_ack_i = 1'b1;
    step();
    n_checks++;
    if (issue_fu_o !== 3'd3 || is_ctrl_flow_o !== 1'b1 || issue_imm_o !== 64'd0) begin
      n_fail++; $display("FAIL jal_zero: fu=%0d ctrl=%b imm=%h, want 3 1 0", issue_fu_o, is_ctrl_flow_o, issue_imm_o);
    end
    fetch_instr_i = 32'hFFDFF0EF;
    step();
    fetch_valid_i = 1'b0;
    n_checks++;
    if (issue_imm_o !== 64'hFFFFFFFFFFFFFFFC || issue_rd_o !== 5'd1 || is_ctrl_flow_o !== 1'b1) begin
      n_fail++; $display("FAIL jal_neg: imm=%h rd=%0d ctrl=%b, want fffffffffffffffc 1 1", issue_imm_o, issue_rd_o, is_ctrl_flow_o);
    end
    step();
    issue_ack_i = 1'b0;
  endtask

  task automatic test_formats();
    logic [31:0] instrs [5];
    logic [2:0]  fus    [5];
    logic [63:0] imms   [5];
    logic [14:0] regs   [5];
    instrs[0] = 32'h01022183; fus[0] = 3'd2; imms[0] = 64'd16;                 regs[0] = {5'd3, 5'd4, 5'd16};
    instrs[1] = 32'hFE532C23; fus[1] = 3'd2; imms[1] = 64'hFFFFFFFFFFFFFFF8;   regs[1] = {5'd24, 5'd6, 5'd5};
    instrs[2] = 32'h023100B3; fus[2] = 3'd5; imms[2] = 64'd0;                  regs[2] = {5'd1, 5'd2, 5'd3};
    instrs[3] = 32'h123452B7; fus[3] = 3'd1; imms[3] = 64'h0000000012345000;   regs[3] = {5'd5, 5'd8, 5'd3};
    instrs[4] = 32'hFFF00113; fus[4] = 3'd1; imms[4] = 64'hFFFFFFFFFFFFFFFF;   regs[4] = {5'd2, 5'd0, 5'd31};
    issue_ack_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      fetch_instr_i = instrs[i]; fetch_pc_i = 64'h1000 + 64'(i * 4); fetch_valid_i = 1'b1;
      step();
      n_checks++;
      if (issue_fu_o !== fus[i] || issue_imm_o !== imms[i] || {issue_rd_o, issue_rs1_o, issue_rs2_o} !== regs[i]) begin
        n_fail++; $display("FAIL format_%0d: fu=%0d imm=%h regs=%h, want fu=%0d imm=%h regs=%h",
                           i, issue_fu_o, issue_imm_o, {issue_rd_o, issue_rs1_o, issue_rs2_o}, fus[i], imms[i], regs[i]);
      end
    end
    fetch_valid_i = 1'b0;
    step();
    issue_ack_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    fetch_instr_i = 32'h000000B3; fetch_pc_i = 64'h2000; fetch_valid_i = 1'b1;
    step();
    fetch_instr_i = 32'h0000006F; fetch_pc_i = 64'h2004;
    n_checks++;
    if (fetch_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL hold_ready: ready=%b, want 0", fetch_ready_o);
    end
    step();
    n_checks++;
    if (issue_valid_o !== 1'b1 || issue_instr_o !== 32'h000000B3 || issue_pc_o !== 64'h2000) begin
      n_fail++; $display("FAIL hold_entry: valid=%b instr=%h pc=%h, want 1 000000b3 2000", issue_valid_o, issue_instr_o, issue_pc_o);
    end
    issue_ack_i = 1'b1;
    #1;
    n_checks++;
    if (fetch_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL ack_ready: ready=%b, want 1", fetch_ready_o);
    end
    @(negedge clk_i);
    step();
    fetch_valid_i = 1'b0; issue_ack_i = 1'b0;
    n_checks++;
    if (issue_valid_o !== 1'b1 || issue_instr_o !== 32'h0000006F || issue_pc_o !== 64'h2004 || is_ctrl_flow_o !== 1'b1) begin
      n_fail++; $display("FAIL no_bubble: valid=%b instr=%h pc=%h ctrl=%b, want 1 0000006f 2004 1",
                         issue_valid_o, issue_instr_o, issue_pc_o, is_ctrl_flow_o);
    end
  endtask

  task automatic test_flush();
    issue_ack_i = 1'b1; flush_i = 1'b1;
    fetch_instr_i = 32'h000000B3; fetch_pc_i = 64'h3000; fetch_valid_i = 1'b1;
    #1;
    n_checks++;
    if (fetch_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_ready: ready=%b, want 0", fetch_ready_o);
    end
    @(negedge clk_i);
    step();
    flush_i = 1'b0; fetch_valid_i = 1'b0; issue_ack_i = 1'b0;
    n_checks++;
    if (issue_valid_o !== 1'b0 || is_ctrl_flow_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_clear: valid=%b ctrl=%b, want 0 0", issue_valid_o, is_ctrl_flow_o);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  priv;
    logic [1:0]  irq;
    logic        irq_en;
    logic        dbg_mode;
    logic [1:0]  fs;
    logic        tvm, tw, tsr;
    logic        ex;
    logic [63:0] cause;
  } ex_vec_t;

  task automatic test_exceptions();
    ex_vec_t v [20];
    v[0]  = '{32'h00000073, 2'd0, 2'b00, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 64'd8};
    v[1]  = '{32'h00000073, 2'd1, 2'b00, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 64'd9};
    v[2]  = '{32'h00000073, 2'd3, 2'b00, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 64'd11};
    v[3]  = '{32'h0000007F, 2'd3, 2'b00, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 64'd2};
    v[4]  = '{32'h000000B3, 2'd3, 2'b01, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h8000000000000007};
    v[5]  = '{32'h000000B3, 2'd3, 2'b11, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h8000000000000007};
    v[6]  = '{32'h000000B3, 2'd3, 2'b10, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h800000000000000B};
    v[7]  = '{32'h000000B3, 2'd3, 2'b01, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0};
    v[8]  = '{32'h000000B3, 2'd3, 2'b01, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0};
    v[9]  = '{32'h00000053, 2'd3, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd2};
    v[10] = '{32'h00000053, 2'd3, 2'b00, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0};
    v[11] = '{32'h30200073, 2'd0, 2'b00, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 64'd2};
    v[12] = '{32'h30200073, 2'd3, 2'b00, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0};
    v[13] = '{32'h00100073, 2'd3, 2'b00, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 64'd3};
    v[14] = '{32'h10500073, 2'd1, 2'b00, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 64'd2};
    v[15] = '{32'h10200073, 2'd0, 2'b00, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 64'd2};
    v[16] = '{32'h12000073, 2'd1, 2'b00, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 64'd2};
    v[17] = '{32'h0000007F, 2'd3, 2'b10, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h800000000000000B};
    v[18] = '{32'h10200073, 2'd1, 2'b00, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0};
    v[19] = '{32'h10500073, 2'd3, 2'b00, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0};
    issue_ack_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      fetch_instr_i = v[i].instr; fetch_pc_i = 64'h4000 + 64'(i * 4); fetch_valid_i = 1'b1;
      priv_lvl_i = v[i].priv; irq_i = v[i].irq; irq_en_i = v[i].irq_en; debug_mode_i = v[i].dbg_mode;
      fs_i = v[i].fs; tvm_i = v[i].tvm; tw_i = v[i].tw; tsr_i = v[i].tsr;
      step();
      n_checks++;
      if (issue_valid_o !== 1'b1 || issue_ex_valid_o !== v[i].ex || issue_ex_cause_o !== v[i].cause) begin
        n_fail++; $display("FAIL exc_%0d: valid=%b ex=%b cause=%h, want 1 %b %h",
                           i, issue_valid_o, issue_ex_valid_o, issue_ex_cause_o, v[i].ex, v[i].cause);
      end
    end
    fetch_valid_i = 1'b0; priv_lvl_i = 2'd3; irq_i = 2'b00; irq_en_i = 1'b0;
    debug_mode_i = 1'b0; fs_i = 2'd1; tvm_i = 1'b0; tw_i = 1'b0; tsr_i = 1'b0;
    step();
    issue_ack_i = 1'b0;
  endtask

  task automatic test_debug_req();
    logic        exp_ex;
    logic [63:0] exp_cause;
`ifdef DECODE_DEBUG_REQ_EN
    exp_ex = 1'b1; exp_cause = 64'd24;
`else
    exp_ex = 1'b0; exp_cause = 64'd0;
`endif
    issue_ack_i = 1'b1; debug_req_i = 1'b1;
    fetch_instr_i = 32'h000000B3; fetch_pc_i = 64'h5000; fetch_valid_i = 1'b1;
    step();
    fetch_valid_i = 1'b0; debug_req_i = 1'b0;
    n_checks++;
    if (issue_ex_valid_o !== exp_ex || issue_ex_cause_o !== exp_cause) begin
      n_fail++; $display("FAIL debug_req: ex=%b cause=%h, want %b %h", issue_ex_valid_o, issue_ex_cause_o, exp_ex, exp_cause);
    end
    step();
    issue_ack_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_jal();
    test_formats();
    test_back_to_back();
    test_flush();
    test_exceptions();
    test_debug_req();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
